// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multiport register file with bypass, zero register, stall and clear sweep
// Optional debug read port enabled by defining REGFILE_DEBUG_PORT_EN.
module regfile_multiport #(
  parameter int LEN         = 32,
  parameter int NB_REG      = 32,
  parameter int NB_ADDR     = 5,
  parameter int NB_RD_PORTS = 2,
  parameter int ZERO_REG    = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_enable,
  input  logic                           i_RegWrite,
  input  logic [NB_ADDR-1:0]             i_write_reg,
  input  logic [LEN-1:0]                 i_write_data,
  input  logic [NB_RD_PORTS*NB_ADDR-1:0] i_read_regs,
  output logic [NB_RD_PORTS*LEN-1:0]     o_read_data,
  output logic                           o_ready
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR-1:0]             i_dbg_addr,
  output logic [LEN-1:0]                 o_dbg_data
`endif
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [NB_ADDR-1:0] LAST_REG = NB_ADDR'(NB_REG - 1);

  logic [LEN-1:0]                 regs [NB_REG];
  state_t                         state, state_next;
  logic [NB_ADDR-1:0]             clr_ptr, clr_ptr_next;
  logic                           ready_next;
  logic                           clr_we;
  logic                           wr_addr_ok;
  logic                           wr_en;
  logic [NB_ADDR-1:0]             rd_addr;
  logic [NB_RD_PORTS*LEN-1:0]     rd_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      o_ready <= 1'b0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
      o_ready <= ready_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    ready_next   = o_ready;
    clr_we       = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we       = 1'b1;
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == LAST_REG) begin
          state_next   = ST_IDLE;
          ready_next   = 1'b1;
          clr_ptr_next = clr_ptr;
        end
      end
      ST_IDLE:  ready_next = 1'b1;
      default:  state_next = ST_CLEAR;
    endcase
  end

  // Writes to register 0 (when hard-wired) and beyond the file are dropped, and never bypassed
  assign wr_addr_ok = (32'(i_write_reg) < NB_REG) && !((ZERO_REG != 0) && (i_write_reg == '0));
  assign wr_en      = i_rst && (state == ST_IDLE) && i_RegWrite && wr_addr_ok;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (clr_we)
        regs[clr_ptr] <= '0;
      else if (wr_en)
        regs[i_write_reg] <= i_write_data;
    end
  end

  always_comb begin
    rd_next = '0;
    rd_addr = '0;
    for (int k = 0; k < NB_RD_PORTS; k++) begin
      rd_addr = i_read_regs[k*NB_ADDR +: NB_ADDR];
      if ((32'(rd_addr) < NB_REG) && !((ZERO_REG != 0) && (rd_addr == '0))) begin
        if (wr_en && (i_write_reg == rd_addr))
          rd_next[k*LEN +: LEN] = i_write_data;
        else
          rd_next[k*LEN +: LEN] = regs[rd_addr];
      end
    end
  end

  // Outputs stay zero through the clear sweep, independent of the stall
  always_ff @(posedge i_clk) begin
    if (!i_rst || (state == ST_CLEAR))
      o_read_data <= '0;
    else if (i_enable)
      o_read_data <= rd_next;
  end

`ifdef REGFILE_DEBUG_PORT_EN
  assign o_dbg_data = ((32'(i_dbg_addr) < NB_REG) && !((ZERO_REG != 0) && (i_dbg_addr == '0)))
                      ? regs[i_dbg_addr] : '0;
`endif

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed self-checking bench for regfile_multiport
module tb_regfile_multiport;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_RegWrite;
  logic [4:0]  i_write_reg;
  logic [31:0] i_write_data;
  logic [9:0]  i_read_regs;
  logic [63:0] o_read_data;
  logic        o_ready;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [4:0]  i_dbg_addr = '0;
  logic [31:0] o_dbg_data;
`endif

  int checks = 0;
  int errors = 0;
  int got;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  regfile_multiport dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_RegWrite   (i_RegWrite),
    .i_write_reg  (i_write_reg),
    .i_write_data (i_write_data),
    .i_read_regs  (i_read_regs),
    .o_read_data  (o_read_data),
    .o_ready      (o_ready)
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    .i_dbg_addr   (i_dbg_addr),
    .o_dbg_data   (o_dbg_data)
`endif
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int port, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge i_clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, o_read_data[e.port*32 +: 32], e.val);
    end
  endtask

  task automatic set_rd(input int a0, input int a1);
    i_read_regs = {5'(a1), 5'(a0)};
  endtask

  task automatic set_wr(input logic we, input int a, input logic [31:0] d);
    i_RegWrite   = we;
    i_write_reg  = 5'(a);
    i_write_data = d;
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge i_clk);
      #1;
      if (o_ready) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    i_rst = 1'b0;
    i_enable = 1'b1;
    set_wr(1'b0, 0, 32'h0);
    set_rd(3, 4);
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready", 32'(o_ready), 32'h0);
    check("rst_data", o_read_data[31:0], 32'h0);

    i_rst = 1'b1;
    wait_ready(got);
    check("ready_edge", got, 32);
    check("clear_data0", o_read_data[31:0], 32'h0);
    check("clear_data1", o_read_data[63:32], 32'h0);

    for (int i = 0; i < 16; i++) begin
      set_rd(2*i, 2*i+1);
      push("sweep_p0", 0, 32'h0);
      push("sweep_p1", 1, 32'h0);
      tick();
    end

    set_wr(1'b1, 5, 32'hDEADBEEF);
    set_rd(1, 2);
    push("pre_wr_p0", 0, 32'h0);
    push("pre_wr_p1", 1, 32'h0);
    tick();
    set_wr(1'b0, 0, 32'h0);
    set_rd(5, 6);
    push("rd_r5", 0, 32'hDEADBEEF);
    push("rd_r6", 1, 32'h0);
    tick();

    set_wr(1'b1, 7, 32'h12345678);
    set_rd(5, 7);
    push("byp_p0_r5", 0, 32'hDEADBEEF);
    push("byp_p1_r7", 1, 32'h12345678);
    tick();
    set_wr(1'b0, 0, 32'h0);
    set_rd(7, 5);
    push("rd_r7", 0, 32'h12345678);
    push("rd_r5_p1", 1, 32'hDEADBEEF);
    tick();

    set_wr(1'b1, 0, 32'hFFFFFFFF);
    set_rd(0, 0);
    push("r0_byp_p0", 0, 32'h0);
    push("r0_byp_p1", 1, 32'h0);
    tick();
    set_wr(1'b0, 0, 32'h0);
    push("r0_p0", 0, 32'h0);
    push("r0_p1", 1, 32'h0);
    tick();

    set_wr(1'b1, 31, 32'hA5A55A5A);
    set_rd(31, 31);
    push("r31_byp_p0", 0, 32'hA5A55A5A);
    push("r31_byp_p1", 1, 32'hA5A55A5A);
    tick();
    set_wr(1'b0, 0, 32'h0);
    push("r31_p0", 0, 32'hA5A55A5A);
    push("r31_p1", 1, 32'hA5A55A5A);
    tick();

    set_wr(1'b1, 2, 32'h11);
    set_rd(5, 7);
    tick();
    set_wr(1'b0, 0, 32'h0);
    set_rd(2, 7);
    push("stall_pre", 0, 32'h11);
    tick();
    i_enable = 1'b0;
    set_wr(1'b1, 3, 32'h22);
    set_rd(3, 5);
    push("stall_hold0", 0, 32'h11);
    push("stall_hold1", 1, 32'h12345678);
    tick();
    set_wr(1'b0, 0, 32'h0);
    push("stall_hold2", 0, 32'h11);
    tick();
    i_enable = 1'b1;
    push("stall_release", 0, 32'h22);
    push("stall_release1", 1, 32'hDEADBEEF);
    tick();

    set_wr(1'b1, 9, 32'h99);
    tick();
    set_wr(1'b0, 0, 32'h0);
    set_rd(9, 9);
    push("r9_set", 0, 32'h99);
    tick();
    i_rst = 1'b0;
    set_wr(1'b1, 9, 32'h77);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
    check("midclr_ready", 32'(o_ready), 32'h0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    wait_ready(got);
    set_wr(1'b0, 0, 32'h0);
    check("reclear_edge", got, 32);
    set_rd(9, 5);
    push("r9_cleared", 0, 32'h0);
    push("r5_cleared", 1, 32'h0);
    tick();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
